// File: rtl/interrupt_fetch_injector_pkg.sv
// Shared constants and state encodings for the interrupt fetch injector.
// IRQ_NONE is also used by the input controller's instruction builders.
package interrupt_fetch_injector_pkg;

  localparam int          INSTR_W  = 32;
  localparam logic [31:0] IRQ_NONE = 32'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GUARD = 2'd2
  } inj_state_t;

endpackage

// File: rtl/irq_fifo.sv
// Synchronous FIFO for queued interrupt words.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module irq_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              last
);

  localparam int            AW  = $clog2(DEPTH);
  localparam logic [AW:0]   ONE = 1;

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign last    = ((wr_ptr - rd_ptr) == ONE);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/interrupt_fetch_injector.sv
// Captures new interrupt words, queues them, and splices them into the CPU
// fetch stream at safe, unstalled slots while holding the PC.
module interrupt_fetch_injector
  import interrupt_fetch_injector_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int GUARD_CYCLES = 1
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] irq_instruction,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               cpu_stall,
  input  logic               cpu_safe_point,
  output logic [INSTR_W-1:0] fetch_instruction,
  output logic               pc_hold,
  output logic               inject_ack,
  output logic               irq_pending,
  output logic               irq_overflow
);

  localparam logic [1:0] GUARD_LOAD = 2'(GUARD_CYCLES);

  inj_state_t         state;
  inj_state_t         state_nxt;
  logic [1:0]         guard_cnt;
  logic [1:0]         guard_nxt;
  logic [INSTR_W-1:0] prev_irq;
  logic [INSTR_W-1:0] head;
  logic               push;
  logic               inject;
  logic               full;
  logic               empty;
  logic               last;

  // A word held over several cycles is only a new request on its first cycle.
  assign push        = (irq_instruction != IRQ_NONE) && (irq_instruction != prev_irq);
  assign irq_pending = !empty;

  irq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (INSTR_W)
  ) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (push),
    .pop    (inject),
    .wdata  (irq_instruction),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .last   (last)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      prev_irq     <= IRQ_NONE;
      state        <= IDLE;
      guard_cnt    <= '0;
      irq_overflow <= 1'b0;
    end else begin
      prev_irq  <= irq_instruction;
      state     <= state_nxt;
      guard_cnt <= guard_nxt;
      if (push && full && !inject) irq_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt         = state;
    guard_nxt         = guard_cnt;
    inject            = 1'b0;
    fetch_instruction = imem_instruction;
    pc_hold           = 1'b0;
    inject_ack        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = ARMED;
      end
      ARMED: begin
        if (!cpu_stall && cpu_safe_point) begin
          inject            = 1'b1;
          fetch_instruction = head;
          pc_hold           = 1'b1;
          inject_ack        = 1'b1;
          if (GUARD_CYCLES != 0) begin
            state_nxt = GUARD;
            guard_nxt = GUARD_LOAD;
          end else if (last && !push) begin
            state_nxt = IDLE;
          end
        end
      end
      GUARD: begin
        // Only unstalled cycles count toward the guard interval.
        if (!cpu_stall) begin
          if (guard_cnt <= 2'd1) begin
            guard_nxt = '0;
            state_nxt = empty ? IDLE : ARMED;
          end else begin
            guard_nxt = guard_cnt - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/interrupt_fetch_injector.md
# interrupt_fetch_injector

CPU-side consumer of the interrupt instruction word produced by the input controller. Detects each new nonzero interrupt instruction, queues it in a small FIFO, and splices queued words into the CPU fetch stream at safe points, holding the PC for the replaced fetch. Sits between instruction memory and the decode stage, clocked by `sysclk`.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2–16.
- `GUARD_CYCLES`, 1: forced passthrough cycles after each injection, 0–3.

Ports:
- `sysclk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_instruction`  in  32  interrupt word from the input controller; nonzero means request; may persist several cycles.
- `imem_instruction`  in  32  normal fetched instruction.
- `cpu_stall`  in  1  fetch/decode stalled this cycle.
- `cpu_safe_point`  in  1  fetch slot may be replaced (not a branch/jump shadow).
- `fetch_instruction`  out  32  word delivered to decode.
- `pc_hold`  out  1  PC must not advance this cycle (fetch slot consumed by injection).
- `inject_ack`  out  1  one-cycle pulse coinciding with an injection.
- `irq_pending`  out  1  FIFO non-empty.
- `irq_overflow`  out  1  sticky; a request was dropped on a full FIFO.

## Operation

- Capture: a register `prev_irq` samples `irq_instruction` every cycle. A push occurs when `irq_instruction != 0` and `irq_instruction != prev_irq`. A word held for N cycles produces exactly one push. A change between two nonzero words produces a second push.
- FIFO: `DEPTH` entries. Read/write pointers are `$clog2(DEPTH)+1` bits; wrap is modulo 2·DEPTH. Full is asserted when the MSBs differ and the low bits are equal. Empty is asserted when the pointers are equal.
- Push on full without a same-cycle pop: the word is dropped and `irq_overflow` is set. `irq_overflow` clears only on reset.
- Push and pop in the same cycle on a full FIFO: both succeed, the count is unchanged, and no overflow is flagged.
- Push on empty: the word is not eligible for pop until the next cycle. There is no bypass.
- FSM states:
  - `IDLE`: FIFO empty. Goes to `ARMED` when the FIFO becomes non-empty.
  - `ARMED`: inject condition is `!cpu_stall && cpu_safe_point`. When it holds: injection, pop, go to `GUARD`, or to `ARMED`/`IDLE` directly when `GUARD_CYCLES == 0`. When it does not hold: stay in `ARMED`.
  - `GUARD`: a counter runs for `GUARD_CYCLES` non-stalled cycles with no injection. It then goes to `ARMED` if the FIFO is non-empty, otherwise to `IDLE`. Stalled cycles do not decrement the counter.
- Injection cycle (combinational in `ARMED`):
  - `fetch_instruction` = FIFO head.
  - `pc_hold` = 1.
  - `inject_ack` = 1.
- All other cycles: `fetch_instruction` = `imem_instruction`, `pc_hold` = 0, `inject_ack` = 0.
- Reset asserted mid-operation: pointers, FSM, guard counter, `prev_irq` and `irq_overflow` clear immediately. Any in-flight injection is abandoned.

## Timing

- Reset values:
  - `fetch_instruction` = `imem_instruction` (passthrough).
  - `pc_hold` = 0, `inject_ack` = 0, `irq_pending` = 0, `irq_overflow` = 0.
  - FSM in `IDLE`, `prev_irq` = 0.
- Latency from a new `irq_instruction` at edge k:
  - Pushed at edge k.
  - `irq_pending` high after edge k.
  - Earliest injection in cycle k+1.
  - Popped at edge k+2.
- `pc_hold`, `inject_ack` and `fetch_instruction` are combinational from registered state plus `cpu_stall` and `cpu_safe_point`. There is no path from `irq_instruction` to the outputs.
- Minimum spacing between injections: 1 + `GUARD_CYCLES` non-stalled cycles.
- A request arriving within one cycle of reset deassertion is captured normally.

## Structure

- Shared package constants: `IRQ_NONE` = 32'b0 (shared with the input controller's builders) and the FSM state encodings `IDLE`/`ARMED`/`GUARD`.
- One sub-module, `irq_fifo`: parameterized synchronous FIFO with push/pop/full/empty. It has the same clock and reset as the top.
- Capture logic, FSM and output mux live in the top.

## Test plan

- Hold `irq_instruction`=32'hA000_0001 for 5 cycles with `cpu_safe_point`=1 and `cpu_stall`=0: exactly one injection of A000_0001 in cycle k+1, `pc_hold`=1 for that single cycle, `irq_pending` returns to 0.
- Send A, B, C, D, E on consecutive cycles with `cpu_safe_point`=0 and DEPTH=4: A–D queued, E dropped, `irq_overflow`=1 and stays 1. Then raise `cpu_safe_point`: A, B, C, D injected in order, with 1 guard cycle between each.
- Keep `cpu_stall`=1 for 3 cycles while `ARMED`: no injection, `pc_hold`=0, `fetch_instruction`=`imem_instruction`. Injection occurs on the first unstalled safe cycle.
- FIFO full and `ARMED`, new word F arrives in the injection cycle: head popped, F pushed, count stays 4, `irq_overflow` unchanged.
- Assert `reset` low during `GUARD` with 2 entries queued: all outputs return to reset values immediately, and no injection occurs after release until a new request arrives.
